prod_accumulator: RTL



---
 rtl/prod_accumulator_if.sv | 21 ++
 rtl/prod_accumulator.sv | 114 +++++++++++
 2 files changed

// File: rtl/prod_accumulator_if.sv
// Product-in / result-out handshake bundle between the multiplier, the accumulator and its consumer.
// Master drives products and output readiness; slave (the accumulator) drives the rest.
interface prod_accumulator_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_prod;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    modport master (
        output in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/prod_accumulator.sv
// Sums COUNT_N unsigned 8-bit products into 16 bits and emits the result as two bytes, low first.
// Latency: out_valid rises the cycle after the final product is accepted; a result takes >= COUNT_N+2 cycles.
// Backpressure: products are refused while the result is pending; output beats hold stable until out_ready.
module prod_accumulator #(
    parameter int COUNT_N  = 4,
    parameter bit SATURATE = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    prod_accumulator_if.slave   bus,
    output logic                ovf,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_ACC     = 2'd0,
        ST_SEND_LO = 2'd1,
        ST_SEND_HI = 2'd2
    } state_t;

    localparam logic [9:0] CNT_LAST = 10'(COUNT_N - 1);

    state_t      state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic        in_rdy;
    logic        accept;
    logic [16:0] sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACC;
            acc_q   <= 16'd0;
            cnt_q   <= 10'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        in_rdy  = (state_q == ST_ACC) && !rst;
        accept  = bus.in_valid && in_rdy;
        sum     = {1'b0, acc_q} + {9'd0, bus.in_prod};
        // clear outranks every handshake, so a product offered alongside it is dropped
        if (clear) begin
            state_d = ST_ACC;
            acc_d   = 16'd0;
            cnt_d   = 10'd0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (accept) begin
                        if (sum[16]) begin
                            ovf_d = 1'b1;
                            acc_d = SATURATE ? 16'hFFFF : sum[15:0];
                        end else begin
                            acc_d = sum[15:0];
                        end
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = 10'd0;
                            state_d = ST_SEND_LO;
                        end else begin
                            cnt_d = cnt_q + 10'd1;
                        end
                    end
                end
                ST_SEND_LO: begin
                    if (bus.out_ready) state_d = ST_SEND_HI;
                end
                ST_SEND_HI: begin
                    if (bus.out_ready) begin
                        state_d = ST_ACC;
                        acc_d   = 16'd0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = ST_ACC;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = in_rdy;
        bus.out_valid = 1'b0;
        bus.out_data  = 8'd0;
        bus.out_last  = 1'b0;
        case (state_q)
            ST_SEND_LO: begin
                bus.out_valid = 1'b1;
                bus.out_data  = acc_q[7:0];
            end
            ST_SEND_HI: begin
                bus.out_valid = 1'b1;
                bus.out_data  = acc_q[15:8];
                bus.out_last  = 1'b1;
            end
            default: ;
        endcase
        ovf  = ovf_q;
        busy = (state_q != ST_ACC) || (cnt_q != 10'd0);
    end

endmodule
